// File: rtl/lbm_stream_unpacker_if.sv
// AXI-Stream beat channel carrying one packed lattice cell per beat.
// Driven by the DMA side (master), consumed by the unpacker (slave).
interface lbm_stream_unpacker_if #(
  parameter int BEAT_WIDTH = 144
) ();
  logic                  tvalid;
  logic [BEAT_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/lbm_stream_unpacker.sv
// Unpacks one lattice cell per AXI-Stream beat into a registered write word plus cell address.
// Latency 1 cycle (accept -> wr_en); tready drops combinationally while the held word is stalled.
module lbm_stream_unpacker #(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_DIR         = 9,
  parameter int DEPTH           = 2500,
  parameter int ADDRESS_WIDTH   = 12,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                             m00_axis_aclk,
  input  logic                             m00_axis_aresetn,
  lbm_stream_unpacker_if.slave             m00_axis,
  input  logic                             wr_ready,
  input  logic                             clear_err,
  output logic                             wr_en,
  output logic [NUM_DIR*DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH-1:0]         wr_addr,
  output logic                             frame_done,
  output logic                             err_short,
  output logic                             err_long,
  output logic [FRAME_CNT_WIDTH-1:0]       frame_count
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] cnt, cnt_nxt;
  logic                     stall;
  logic                     accept;
  logic                     load;
  logic                     done_nxt;
  logic                     good;
  logic                     set_short;
  logic                     set_long;

  assign stall           = wr_en & ~wr_ready;
  // tready depends only on state and the holding stage, never on tvalid
  assign m00_axis.tready = (state == FLUSH) | ((state == RECV) & ~stall);
  assign accept          = m00_axis.tvalid & m00_axis.tready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    done_nxt  = 1'b0;
    good      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m00_axis.tvalid) state_nxt = RECV;
      end
      RECV: begin
        if (accept) begin
          load = 1'b1;
          if (m00_axis.tlast) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            good      = (cnt == LAST_IDX);
            set_short = (cnt != LAST_IDX);
          end else if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = FLUSH;
            set_long  = 1'b1;
          end else begin
            cnt_nxt = cnt + ADDRESS_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (accept && m00_axis.tlast) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_en       <= 1'b0;
      wr_data     <= '0;
      wr_addr     <= '0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (load) begin
        wr_en   <= 1'b1;
        wr_data <= m00_axis.tdata;
        wr_addr <= cnt;
      end else if (wr_en && wr_ready) begin
        wr_en <= 1'b0;
      end
      frame_done <= done_nxt;
      // a flag being set on the same edge takes priority over clear_err
      err_short  <= set_short | (err_short & ~clear_err);
      err_long   <= set_long | (err_long & ~clear_err);
      if (good) frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_lbm_stream_unpacker.sv
// Directed bench: cycle table on a DEPTH=4 instance plus reset and wide-parameter sequences.
module tb_lbm_stream_unpacker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DEPTH=4, 9x16 instance
  lbm_stream_unpacker_if #(.BEAT_WIDTH(144)) ax ();
  logic         wrr, ce;
  logic         wen, fd, es, el;
  logic [143:0] wdat;
  logic [1:0]   waddr;
  logic [15:0]  fc;

  lbm_stream_unpacker #(
    .DATA_WIDTH(16), .NUM_DIR(9), .DEPTH(4), .ADDRESS_WIDTH(2), .FRAME_CNT_WIDTH(16)
  ) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .m00_axis(ax),
    .wr_ready(wrr), .clear_err(ce), .wr_en(wen), .wr_data(wdat), .wr_addr(waddr),
    .frame_done(fd), .err_short(es), .err_long(el), .frame_count(fc)
  );

  // 19x32, DEPTH=2500 instance
  lbm_stream_unpacker_if #(.BEAT_WIDTH(608)) ax2 ();
  logic         wrr2, ce2;
  logic         wen2, fd2, es2, el2;
  logic [607:0] wdat2;
  logic [11:0]  waddr2;
  logic [15:0]  fc2;

  lbm_stream_unpacker #(
    .DATA_WIDTH(32), .NUM_DIR(19), .DEPTH(2500), .ADDRESS_WIDTH(12), .FRAME_CNT_WIDTH(16)
  ) dut2 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .m00_axis(ax2),
    .wr_ready(wrr2), .clear_err(ce2), .wr_en(wen2), .wr_data(wdat2), .wr_addr(waddr2),
    .frame_done(fd2), .err_short(es2), .err_long(el2), .frame_count(fc2)
  );

  function automatic logic [143:0] beat9(input int k);
    logic [143:0] v;
    for (int d = 0; d < 9; d++) v[d*16 +: 16] = 16'(k * 16 + d);
    return v;
  endfunction

  function automatic logic [607:0] beat19(input int k);
    logic [607:0] v;
    for (int d = 0; d < 19; d++) v[d*32 +: 32] = {16'(k), 16'(d)};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [607:0] act, input logic [607:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic tv; logic tl; int k; logic wr; logic cl;
    logic e_trdy; logic e_wen; int e_addr; int e_k;
    logic e_fd; logic e_es; logic e_el; int e_fc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic tv, tl, input int k, input logic wr, cl,
                     input logic trdy, w, input int addr, ek,
                     input logic f, s, l, input int cnt);
    vec_t r;
    r.tv = tv; r.tl = tl; r.k = k; r.wr = wr; r.cl = cl;
    r.e_trdy = trdy; r.e_wen = w; r.e_addr = addr; r.e_k = ek;
    r.e_fd = f; r.e_es = s; r.e_el = l; r.e_fc = cnt;
    vq.push_back(r);
  endtask

  initial begin
    int k, nw, fdc, bad, last_addr;
    logic [31:0] lane18;

    // Rows: inputs (tvalid,tlast,beat,wr_ready,clear_err) | outputs seen in that cycle
    // good frame
    add(1,0,0,1,0, 0,0,0,0, 0,0,0,0);
    add(1,0,0,1,0, 1,0,0,0, 0,0,0,0);
    add(1,0,1,1,0, 1,1,0,0, 0,0,0,0);
    add(1,0,2,1,0, 1,1,1,1, 0,0,0,0);
    add(1,1,3,1,0, 1,1,2,2, 0,0,0,0);
    add(0,0,0,1,0, 0,1,3,3, 1,0,0,1);
    add(0,0,0,1,0, 0,0,3,3, 0,0,0,1);
    // back-pressure: wr_ready low three cycles while beat 1 is held
    add(1,0,0,1,0, 0,0,3,0, 0,0,0,1);
    add(1,0,0,1,0, 1,0,3,0, 0,0,0,1);
    add(1,0,1,1,0, 1,1,0,0, 0,0,0,1);
    add(1,0,2,0,0, 0,1,1,1, 0,0,0,1);
    add(1,0,2,0,0, 0,1,1,1, 0,0,0,1);
    add(1,0,2,0,0, 0,1,1,1, 0,0,0,1);
    add(1,0,2,1,0, 1,1,1,1, 0,0,0,1);
    add(1,1,3,1,0, 1,1,2,2, 0,0,0,1);
    add(0,0,0,1,0, 0,1,3,3, 1,0,0,2);
    add(0,0,0,1,0, 0,0,3,3, 0,0,0,2);
    // short frame, then clear and a good frame from address 0
    add(1,0,0,1,0, 0,0,3,0, 0,0,0,2);
    add(1,0,0,1,0, 1,0,3,0, 0,0,0,2);
    add(1,1,1,1,0, 1,1,0,0, 0,0,0,2);
    add(0,0,0,1,0, 0,1,1,1, 1,1,0,2);
    add(0,0,0,1,0, 0,0,1,1, 0,1,0,2);
    add(1,0,0,1,1, 0,0,1,0, 0,1,0,2);
    add(1,0,0,1,0, 1,0,1,0, 0,0,0,2);
    add(1,0,1,1,0, 1,1,0,0, 0,0,0,2);
    add(1,0,2,1,0, 1,1,1,1, 0,0,0,2);
    add(1,1,3,1,0, 1,1,2,2, 0,0,0,2);
    add(0,0,0,1,0, 0,1,3,3, 1,0,0,3);
    add(0,0,0,1,0, 0,0,3,3, 0,0,0,3);
    // long frame: beats 4,5 flushed
    add(1,0,0,1,0, 0,0,3,0, 0,0,0,3);
    add(1,0,0,1,0, 1,0,3,0, 0,0,0,3);
    add(1,0,1,1,0, 1,1,0,0, 0,0,0,3);
    add(1,0,2,1,0, 1,1,1,1, 0,0,0,3);
    add(1,0,3,1,0, 1,1,2,2, 0,0,0,3);
    add(1,0,4,1,0, 1,1,3,3, 0,0,1,3);
    add(1,1,5,1,0, 1,0,3,3, 0,0,1,3);
    add(0,0,0,1,0, 0,0,3,3, 1,0,1,3);
    add(0,0,0,1,1, 0,0,3,3, 0,0,1,3);
    add(0,0,0,1,0, 0,0,3,3, 0,0,0,3);

    rst_n = 1'b0;
    ax.tvalid = 1'b0; ax.tlast = 1'b0; ax.tdata = '0; wrr = 1'b1; ce = 1'b0;
    ax2.tvalid = 1'b0; ax2.tlast = 1'b0; ax2.tdata = '0; wrr2 = 1'b1; ce2 = 1'b0;
    #12;
    chk("rst_wen", wen, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_fc", fc, 0);
    chk("rst_tready", ax.tready, 0);
    chk("rst_flags", {fd, es, el}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      ax.tvalid = vq[i].tv; ax.tlast = vq[i].tl; ax.tdata = beat9(vq[i].k);
      wrr = vq[i].wr; ce = vq[i].cl;
      #1;
      chk($sformatf("row%0d_tready", i), ax.tready, vq[i].e_trdy);
      chk($sformatf("row%0d_wr_en", i), wen, vq[i].e_wen);
      chk($sformatf("row%0d_wr_addr", i), waddr, vq[i].e_addr);
      if (vq[i].e_wen) chk($sformatf("row%0d_wr_data", i), wdat, beat9(vq[i].e_k));
      chk($sformatf("row%0d_frame_done", i), fd, vq[i].e_fd);
      chk($sformatf("row%0d_err_short", i), es, vq[i].e_es);
      chk($sformatf("row%0d_err_long", i), el, vq[i].e_el);
      chk($sformatf("row%0d_frame_count", i), fc, vq[i].e_fc);
    end

    // asynchronous reset with a stalled word pending after beat 2
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      ax.tvalid = 1'b1; ax.tlast = 1'b0; ax.tdata = beat9(b == 0 ? 0 : b - 1); wrr = 1'b1;
    end
    @(negedge clk);
    ax.tvalid = 1'b0; wrr = 1'b0;
    #1;
    chk("prerst_wen", wen, 1);
    chk("prerst_addr", waddr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", wen, 0);
    chk("arst_addr", waddr, 0);
    chk("arst_fc", fc, 0);
    chk("arst_tready", ax.tready, 0);
    @(negedge clk);
    rst_n = 1'b1; wrr = 1'b1;
    k = 0; nw = 0;
    for (int c = 0; c < 20 && nw < 4; c++) begin
      @(negedge clk);
      ax.tvalid = (k < 4); ax.tlast = (k == 3); ax.tdata = beat9(k);
      #1;
      if (wen) begin
        chk($sformatf("post_rst_addr%0d", nw), waddr, nw);
        chk($sformatf("post_rst_data%0d", nw), wdat, beat9(nw));
        nw++;
      end
      if (ax.tready && ax.tvalid) k++;
    end
    chk("post_rst_writes", nw, 4);
    chk("post_rst_fc", fc, 1);
    @(negedge clk);
    ax.tvalid = 1'b0;

    // wide-parameter full frame
    k = 0; nw = 0; fdc = 0; bad = 0; last_addr = -1; lane18 = '0;
    for (int c = 0; c < 2700 && nw < 2500; c++) begin
      @(negedge clk);
      ax2.tvalid = (k < 2500); ax2.tlast = (k == 2499); ax2.tdata = beat19(k);
      #1;
      if (fd2) fdc++;
      if (wen2) begin
        if (waddr2 !== 12'(nw) || wdat2 !== beat19(nw)) bad++;
        last_addr = int'(waddr2);
        lane18 = wdat2[607:576];
        nw++;
      end
      if (ax2.tready && ax2.tvalid) k++;
    end
    @(negedge clk);
    ax2.tvalid = 1'b0;
    chk("sweep_writes", nw, 2500);
    chk("sweep_bad_words", bad, 0);
    chk("sweep_last_addr", last_addr, 2499);
    chk("sweep_lane18", lane18, {16'd2499, 16'd18});
    chk("sweep_frame_done", fdc, 1);
    chk("sweep_fc", fc2, 1);
    chk("sweep_errs", {es2, el2}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbm_stream_unpacker.md
# lbm_stream_unpacker

Parametrised AXI-Stream slave that receives one lattice-Boltzmann cell per beat, with NUM_DIR distribution values packed per beat, and unpacks each beat into a registered per-direction write word plus a linear cell address. It sits between the DDR read DMA and the BRAM lattice banks. Compared with the fixed 9×16-bit pixel reader it adds:
- generic width, direction count and depth;
- downstream back-pressure;
- frame-length checking, with flushing of over-long frames;
- a completed-frame counter.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per direction value
- NUM_DIR, 9, directions per cell (beat width = NUM_DIR*DATA_WIDTH)
- DEPTH, 2500, cells per frame (≥2)
- ADDRESS_WIDTH, 12, width of wr_addr (2^ADDRESS_WIDTH ≥ DEPTH)
- FRAME_CNT_WIDTH, 16, width of frame_count

Ports:
- m00_axis_aclk  in  1  clock; all logic rising-edge
- m00_axis_aresetn  in  1  reset, asynchronous, active-low
- m00_axis_tvalid  in  1  beat valid
- m00_axis_tdata  in  NUM_DIR*DATA_WIDTH  direction d at bits [d*DATA_WIDTH +: DATA_WIDTH], d=0 lowest (d=0 N, 1 rest, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW for NUM_DIR=9)
- m00_axis_tlast  in  1  last cell of frame
- m00_axis_tready  out  1  beat accept
- wr_ready  in  1  BRAM side can take wr_data this cycle
- clear_err  in  1  synchronous clear of sticky error flags
- wr_en  out  1  wr_data/wr_addr valid
- wr_data  out  NUM_DIR*DATA_WIDTH  unpacked cell, same lane order as tdata
- wr_addr  out  ADDRESS_WIDTH  cell index within frame
- frame_done  out  1  one-cycle pulse when a frame ends (normal or error)
- err_short  out  1  sticky: tlast before DEPTH cells
- err_long  out  1  sticky: DEPTH cells without tlast
- frame_count  out  FRAME_CNT_WIDTH  frames ended without error, wraps

## Operation
- States: IDLE, RECV, FLUSH.
- All outputs reset to 0. Internal cell counter cnt resets to 0. State resets to IDLE.
- IDLE:
  - m00_axis_tready=0; cnt held at 0.
  - tvalid=1 → RECV.
- Output register:
  - A one-word holding stage with wr_en as its full flag.
  - Downstream consumes the word on the cycle wr_en & wr_ready.
  - stall = wr_en & ~wr_ready.
- tready:
  - RECV: tready = ~stall.
  - FLUSH: tready = 1 (beats are discarded, never written).
- Accept in RECV = tvalid & tready. On accept:
  - wr_data ← tdata; wr_addr ← cnt; wr_en ← 1; cnt ← cnt+1.
- If no accept and the held word is consumed: wr_en ← 0.
- Accepted beat with tlast:
  - cnt = DEPTH-1 → good frame: frame_done pulse, frame_count+1, cnt←0, → IDLE.
  - cnt < DEPTH-1 → err_short←1, frame_done pulse, frame_count unchanged, cnt←0, → IDLE. That beat is still written.
- Accepted beat at cnt = DEPTH-1 without tlast:
  - Beat is written; err_long←1; cnt←0; → FLUSH.
- FLUSH:
  - Accepted beats are dropped; wr_en and wr_addr are unaffected.
  - Accepted beat with tlast → frame_done pulse, → IDLE.
- clear_err=1: err_short, err_long ← 0 next cycle. A simultaneous set wins over clear.
- Addressing: wr_addr never exceeds DEPTH-1. cnt is ADDRESS_WIDTH bits and compared against DEPTH-1, not against wraparound.
- frame_count is modulo 2^FRAME_CNT_WIDTH.
- tstrb is not present. All lanes are always valid.

## Timing
- IDLE→RECV costs one bubble cycle: the first beat is accepted at the earliest one cycle after tvalid rises.
- Latency: beat accepted at edge N → wr_en/wr_data/wr_addr valid after edge N, i.e. during cycle N+1.
- Throughput is one beat per cycle while wr_ready=1.
- With wr_ready=0 and wr_en=1: tready=0 combinationally in the same cycle; wr_data/wr_addr held stable.
- When wr_ready rises, tready rises in the same cycle (no bubble).
- frame_done is registered and asserts in the cycle after the terminating beat is accepted.
- frame_count and err_* update on that same edge.
- tready is combinational from state, wr_en and wr_ready only, never from tvalid.
- Reset asserted mid-frame:
  - All outputs and state clear immediately (asynchronous).
  - A pending wr_en word is lost.
  - After release, the next tvalid starts a fresh frame at wr_addr 0.

## Test plan
DEPTH=4, NUM_DIR=9, DATA_WIDTH=16 unless stated.
- Good frame, wr_ready=1: 4 beats, lane d of beat k = 16'h(k*16+d), tlast on beat 3 → wr_addr 0,1,2,3 with matching lanes; frame_done one pulse; frame_count=1; err flags 0.
- Back-pressure: wr_ready low for 3 cycles after the beat-1 write → tready low those 3 cycles; wr_addr=1 held with stable data; no beat lost or duplicated; addresses 0..3 in order.
- Short frame: tlast on beat 1 → writes at addr 0,1; err_short=1; frame_done pulse; frame_count unchanged. A following good frame restarts at addr 0 and gives frame_count=1.
- Long frame: 6 beats, tlast on beat 5 → writes only at addr 0..3; err_long=1 after beat 3; beats 4,5 accepted and dropped; frame_done after beat 5; clear_err then clears err_long.
- Async reset asserted after beat 2 with wr_ready=0 → wr_en, wr_addr, frame_count, tready go to 0 immediately; next frame writes from addr 0.
- Parameter sweep NUM_DIR=19, DATA_WIDTH=32, DEPTH=2500: full frame gives 2500 writes, last wr_addr=2499, lane 18 equals tdata[607:576].
